// File: rtl/butterfly_ctrl_pkg.sv
// Shared definitions for the in-place radix-2 butterfly sequencer.
package butterfly_ctrl_pkg;

    // Controller states: wait for start, issue pairs, let the pipeline empty, report completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bfly_state_t;

    // Memory read latency plus the registered add/sub stage between read and write-back.
    localparam int RD_LAT   = 1;
    localparam int BF_LAT   = 1;
    localparam int PIPE_LAT = RD_LAT + BF_LAT;

endpackage

// File: rtl/butterfly_ctrl_wr_delay.sv
// Delay line that turns the read strobe/addresses into the matching write strobe/addresses.
module bfly_wr_delay
    import butterfly_ctrl_pkg::*;
#(
    parameter int AW    = 3,
    parameter int DEPTH = PIPE_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic [AW-1:0] in_addr_a,
    input  logic [AW-1:0] in_addr_b,
    output logic          out_en,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b
);

    logic          en_q     [DEPTH];
    logic [AW-1:0] addr_a_q [DEPTH];
    logic [AW-1:0] addr_b_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            if (gi == 0) begin : g_first
                // First tap captures the live read request.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        en_q[gi]     <= 1'b0;
                        addr_a_q[gi] <= '0;
                        addr_b_q[gi] <= '0;
                    end else begin
                        en_q[gi]     <= in_en;
                        addr_a_q[gi] <= in_addr_a;
                        addr_b_q[gi] <= in_addr_b;
                    end
                end
            end else begin : g_next
                // Later taps shift the request one cycle further down the line.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        en_q[gi]     <= 1'b0;
                        addr_a_q[gi] <= '0;
                        addr_b_q[gi] <= '0;
                    end else begin
                        en_q[gi]     <= en_q[gi-1];
                        addr_a_q[gi] <= addr_a_q[gi-1];
                        addr_b_q[gi] <= addr_b_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_en     = en_q[DEPTH-1];
    assign out_addr_a = addr_a_q[DEPTH-1];
    assign out_addr_b = addr_b_q[DEPTH-1];

endmodule

// File: rtl/butterfly_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 transform of length 2**M.
module butterfly_ctrl
    import butterfly_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [3:0]   stage,
    output logic         rd_en,
    output logic [M-1:0] rd_addr_a,
    output logic [M-1:0] rd_addr_b,
    output logic         wr_en,
    output logic [M-1:0] wr_addr_a,
    output logic [M-1:0] wr_addr_b
);

    // Data width 2**N only matters to the datapath outside this block.
    if (M < 1 || M > 15 || N < 0) begin : g_bad_params
        $error("butterfly_ctrl: M must be within 1..15 and N non-negative");
    end

    localparam logic [M-1:0] ONE        = M'(1);
    localparam logic [M-1:0] J_LAST     = M'((1 << (M-1)) - 1);
    localparam logic [3:0]   STAGE_LAST = 4'(M-1);

    bfly_state_t  state_q, state_d;
    logic [3:0]   stage_q, stage_d;
    logic [M-1:0] j_q, j_d;
    logic         drain_q, drain_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         rd_en_q, rd_en_d;
    logic [M-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [M-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [M-1:0] low_mask;
    logic [M-1:0] pair_addr;

    // Next state, stage and pair index; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = 4'd0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    j_d = j_q + ONE;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    if (stage_q < STAGE_LAST) begin
                        state_d = RUN;
                        stage_d = stage_q + 4'd1;
                        j_d     = '0;
                    end else begin
                        state_d = DONE;
                        stage_d = 4'd0;
                    end
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand a is j with a zero spliced in at bit position stage; b sets that bit.
    always_comb begin
        low_mask    = (ONE << stage_d) - ONE;
        pair_addr   = ((j_d & ~low_mask) << 1) | (j_d & low_mask);
        rd_en_d     = (state_d == RUN);
        busy_d      = (state_d == RUN) || (state_d == DRAIN);
        done_d      = (state_d == DONE);
        rd_addr_a_d = rd_en_d ? pair_addr : '0;
        rd_addr_b_d = rd_en_d ? (pair_addr | (ONE << stage_d)) : '0;
    end

    // Controller registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= 4'd0;
            j_q         <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            j_q         <= j_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
        end
    end

    bfly_wr_delay #(
        .AW    (M),
        .DEPTH (PIPE_LAT)
    ) u_wr_delay (
        .clk        (clk),
        .rst        (rst),
        .in_en      (rd_en_q),
        .in_addr_a  (rd_addr_a_q),
        .in_addr_b  (rd_addr_b_q),
        .out_en     (wr_en),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;

endmodule

// File: tb/tb_butterfly_ctrl.sv
// Bench for butterfly_ctrl: per-cycle model comparison for M=3 and M=1 plus closed-loop data checks.
module tb_butterfly_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start3 = 1'b0;
    logic start1 = 1'b0;

    logic       d3_busy, d3_done, d3_rd_en, d3_wr_en;
    logic [3:0] d3_stage;
    logic [2:0] d3_rd_a, d3_rd_b, d3_wr_a, d3_wr_b;

    logic       d1_busy, d1_done, d1_rd_en, d1_wr_en;
    logic [3:0] d1_stage;
    logic [0:0] d1_rd_a, d1_rd_b, d1_wr_a, d1_wr_b;

    butterfly_ctrl #(.N(4), .M(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(d3_busy), .done(d3_done),
        .stage(d3_stage), .rd_en(d3_rd_en), .rd_addr_a(d3_rd_a), .rd_addr_b(d3_rd_b),
        .wr_en(d3_wr_en), .wr_addr_a(d3_wr_a), .wr_addr_b(d3_wr_b)
    );

    butterfly_ctrl #(.N(4), .M(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(d1_busy), .done(d1_done),
        .stage(d1_stage), .rd_en(d1_rd_en), .rd_addr_a(d1_rd_a), .rd_addr_b(d1_rd_b),
        .wr_en(d1_wr_en), .wr_addr_a(d1_wr_a), .wr_addr_b(d1_wr_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (timeline view of one transform) ----------------
    typedef struct packed {
        int phase;      // 0 idle, 1 transform running, 2 completion cycle
        int t;          // cycles since transform began
        int stage;
        int rd_a, rd_b, h_a, h_b, wr_a, wr_b;
        bit busy, done, rd_en, h_en, wr_en;
    } mdl_t;

    function automatic mdl_t model_step(input mdl_t s, input logic r, input logic st, input int mm);
        mdl_t n;
        int per, tot, j, stg, pw;
        n = s;
        if (r) begin
            n = '0;
            return n;
        end
        n.wr_en = s.h_en; n.wr_a = s.h_a; n.wr_b = s.h_b;
        n.h_en  = s.rd_en; n.h_a = s.rd_a; n.h_b = s.rd_b;
        per = (1 << (mm - 1)) + 2;
        tot = mm * per;
        case (s.phase)
            0: if (st) begin n.phase = 1; n.t = 0; end
            1: begin n.t = s.t + 1; if (n.t == tot) n.phase = 2; end
            default: n.phase = 0;
        endcase
        n.busy = (n.phase == 1);
        n.done = (n.phase == 2);
        n.stage = 0; n.rd_en = 1'b0; n.rd_a = 0; n.rd_b = 0;
        if (n.phase == 1) begin
            stg = n.t / per;
            j   = n.t % per;
            n.stage = stg;
            if (j < per - 2) begin
                pw = 1 << stg;
                n.rd_en = 1'b1;
                n.rd_a  = (j / pw) * (2 * pw) + (j % pw);
                n.rd_b  = n.rd_a + pw;
            end
        end
        return n;
    endfunction

    mdl_t m3 = '0;
    mdl_t m1 = '0;
    bit chk_on = 1'b0;

    always @(posedge clk) begin
        m3 = model_step(m3, rst, start3, 3);
        m1 = model_step(m1, rst, start1, 1);
    end

    // Single compare process: every cycle, both DUTs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m3_busy",  32'(d3_busy),  32'(m3.busy));
            chk("m3_done",  32'(d3_done),  32'(m3.done));
            chk("m3_stage", 32'(d3_stage), 32'(m3.stage));
            chk("m3_rd_en", 32'(d3_rd_en), 32'(m3.rd_en));
            chk("m3_rd_a",  32'(d3_rd_a),  32'(m3.rd_a));
            chk("m3_rd_b",  32'(d3_rd_b),  32'(m3.rd_b));
            chk("m3_wr_en", 32'(d3_wr_en), 32'(m3.wr_en));
            chk("m3_wr_a",  32'(d3_wr_a),  32'(m3.wr_a));
            chk("m3_wr_b",  32'(d3_wr_b),  32'(m3.wr_b));
            chk("m1_busy",  32'(d1_busy),  32'(m1.busy));
            chk("m1_done",  32'(d1_done),  32'(m1.done));
            chk("m1_stage", 32'(d1_stage), 32'(m1.stage));
            chk("m1_rd_en", 32'(d1_rd_en), 32'(m1.rd_en));
            chk("m1_rd_a",  32'(d1_rd_a),  32'(m1.rd_a));
            chk("m1_rd_b",  32'(d1_rd_b),  32'(m1.rd_b));
            chk("m1_wr_en", 32'(d1_wr_en), 32'(m1.wr_en));
            chk("m1_wr_a",  32'(d1_wr_a),  32'(m1.wr_a));
            chk("m1_wr_b",  32'(d1_wr_b),  32'(m1.wr_b));
        end
    end

    // ---------------- closed-loop memory + registered add/sub butterfly (M=3, 16-bit) ----------------
    logic [15:0] mem    [8];
    logic [15:0] ld_vec [8];
    bit          ld_en = 1'b0;
    logic [15:0] rda, rdb, y1, y2;

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 8; i++) mem[i] <= ld_vec[i];
        end else if (d3_wr_en) begin
            mem[d3_wr_a] <= y1;
            mem[d3_wr_b] <= y2;
        end
        if (d3_rd_en) begin
            rda <= mem[d3_rd_a];
            rdb <= mem[d3_rd_b];
        end
        y1 <= rda + rdb;
        y2 <= rda - rdb;
    end

    // ---------------- trace recorders ----------------
    bit rec_on = 1'b0;
    int rd3_q[$], wr3_q[$], rd1_q[$], wr1_q[$];
    int busy3_cnt, busy1_cnt, done1_cnt, cyc;
    int rd3_first, wr3_first;

    always @(negedge clk) begin
        cyc++;
        if (rec_on) begin
            if (d3_rd_en) begin
                if (rd3_q.size() == 0) rd3_first = cyc;
                rd3_q.push_back(int'(d3_rd_a) * 16 + int'(d3_rd_b));
            end
            if (d3_wr_en) begin
                if (wr3_q.size() == 0) wr3_first = cyc;
                wr3_q.push_back(int'(d3_wr_a) * 16 + int'(d3_wr_b));
            end
            if (d1_rd_en) rd1_q.push_back(int'(d1_rd_a) * 16 + int'(d1_rd_b));
            if (d1_wr_en) wr1_q.push_back(int'(d1_wr_a) * 16 + int'(d1_wr_b));
            if (d3_busy) busy3_cnt++;
            if (d1_busy) busy1_cnt++;
            if (d1_done) done1_cnt++;
        end
    end

    int exp_pairs [12] = '{8'h01, 8'h23, 8'h45, 8'h67,
                           8'h02, 8'h13, 8'h46, 8'h57,
                           8'h04, 8'h15, 8'h26, 8'h37};

    task automatic rec_start();
        rd3_q.delete(); wr3_q.delete(); rd1_q.delete(); wr1_q.delete();
        busy3_cnt = 0; busy1_cnt = 0; done1_cnt = 0;
        rd3_first = -1; wr3_first = -1;
        rec_on = 1'b1;
    endtask

    task automatic wait_done3(input string tag);
        int n;
        n = 0;
        while (d3_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(d3_done), 32'd1);
        chk({tag, "_busy_low_at_done"}, 32'(d3_busy), 32'd0);
    endtask

    task automatic check_trace3(input string tag);
        chk({tag, "_rd_count"}, 32'(rd3_q.size()), 32'd12);
        chk({tag, "_wr_count"}, 32'(wr3_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < rd3_q.size()) chk({tag, "_rd_pair"}, 32'(rd3_q[i]), 32'(exp_pairs[i]));
            if (i < wr3_q.size()) chk({tag, "_wr_pair"}, 32'(wr3_q[i]), 32'(exp_pairs[i]));
        end
        chk({tag, "_wr_lag"}, 32'(wr3_first - rd3_first), 32'd2);
        chk({tag, "_busy_cycles"}, 32'(busy3_cnt), 32'd18);
    endtask

    task automatic run_data(input string tag, input logic [15:0] v0, input logic [15:0] vr,
                            input logic [15:0] e0, input logic [15:0] er);
        @(negedge clk);
        ld_vec[0] = v0;
        for (int i = 1; i < 8; i++) ld_vec[i] = vr;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
        rec_start();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done3(tag);
        rec_on = 1'b0;
        check_trace3(tag);
        @(negedge clk);
        chk({tag, "_mem0"}, 32'(mem[0]), 32'(e0));
        for (int i = 1; i < 8; i++) chk({tag, "_memr"}, 32'(mem[i]), 32'(er));
        $display("transform %s: mem0=%h mem1=%h mem7=%h", tag, mem[0], mem[1], mem[7]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dn, n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_busy",  32'(d3_busy),  32'd0);
        chk("reset_rd_en", 32'(d3_rd_en), 32'd0);
        chk("reset_wr_en", 32'(d3_wr_en), 32'd0);
        chk("reset_stage", 32'(d3_stage), 32'd0);
        $display("reset: busy=%0d rd_en=%0d wr_en=%0d", d3_busy, d3_rd_en, d3_wr_en);

        // First run also exercises the M=1 instance.
        rec_start();
        start1 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        wait_done3("pairs");
        rec_on = 1'b0;
        check_trace3("pairs");
        chk("m1_rd_count", 32'(rd1_q.size()), 32'd1);
        chk("m1_wr_count", 32'(wr1_q.size()), 32'd1);
        if (rd1_q.size() > 0) chk("m1_rd_pair", 32'(rd1_q[0]), 32'h01);
        if (wr1_q.size() > 0) chk("m1_wr_pair", 32'(wr1_q[0]), 32'h01);
        chk("m1_busy_cycles", 32'(busy1_cnt), 32'd3);
        chk("m1_done_pulses", 32'(done1_cnt), 32'd1);
        $display("pairs run: m3 busy=%0d m1 busy=%0d", busy3_cnt, busy1_cnt);

        run_data("ones",    16'h0001, 16'h0001, 16'h0008, 16'h0000);
        run_data("impulse", 16'h0001, 16'h0000, 16'h0001, 16'h0001);
        run_data("wrap",    16'h4000, 16'h4000, 16'h0000, 16'h0000);

        // start held high: restarts only after passing through IDLE (one transform per 20 cycles).
        @(negedge clk);
        start3 = 1'b1;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d3_done) dn++;
        end
        start3 = 1'b0;
        chk("held_start_dones", 32'(dn), 32'd3);
        $display("held start: done pulses=%0d", dn);
        repeat (3) @(negedge clk);

        // Abort in stage 1 at pair j=2, then a fresh transform.
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!(d3_stage == 4'd1 && d3_rd_en && d3_rd_a == 3'd4 && d3_rd_b == 3'd6) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_point_found", 32'(n < 40), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  32'(d3_busy),  32'd0);
        chk("abort_rd_en", 32'(d3_rd_en), 32'd0);
        chk("abort_wr_en", 32'(d3_wr_en), 32'd0);
        chk("abort_done",  32'(d3_done),  32'd0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d3_wr_en || d3_done) dn++;
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        $display("abort: stray write/done cycles=%0d", dn);
        rec_start();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done3("after_abort");
        rec_on = 1'b0;
        check_trace3("after_abort");
        $display("after abort: reads=%0d writes=%0d busy=%0d", rd3_q.size(), wr3_q.size(), busy3_cnt);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
